// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter
//   Round-robin arbiter that shares one 4-way one-hot address decoder between
//   four requesters. A single winner is registered, its index drives the
//   decoder address with enable=1, and the decoder's one-hot line is mirrored
//   back out as the grant vector. The grant is held until the owner releases.
//   After each release there is one turnaround cycle, and then priority rotates.
//
//   Optional feature: define ARB_TIMEOUT_EN to add an 8-bit hold counter. The
//   counter forces a release after MAX_HOLD grant cycles and pulses timeout_o.
//   Without the macro, a grant is held until the owner lets go, and timeout_o
//   stays 0.
//
//   All outputs come from flops. No combinational path runs from req_i/done_i
//   to any output.

module decoder_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        req_i,
  input  logic [3:0]        done_i,
  output logic [ADDR_W-1:0] dec_addr_o,
  output logic              dec_en_o,
  output logic [3:0]        grant_o,
  output logic [ADDR_W-1:0] owner_idx_o,
  output logic              timeout_o
);

  // The one-hot width is tied to the decoder. Reject other shapes at elaboration.
  if (NUM_REQ != 4 || ADDR_W != 2 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("decoder_rr_arbiter: NUM_REQ=4, ADDR_W=2, MAX_HOLD in 1..255 required");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_REL   = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   ptr_q,      ptr_d;
  logic [ADDR_W-1:0]   owner_q,    owner_d;
  logic [ADDR_W-1:0]   dec_addr_q, dec_addr_d;
  logic                dec_en_q,   dec_en_d;
  logic [NUM_REQ-1:0]  grant_q,    grant_d;
  logic                timeout_q,  timeout_d;

  logic                win_found;
  logic [ADDR_W-1:0]   win_idx;
  logic [ADDR_W-1:0]   scan_idx;
  logic                owner_rel;
  logic                expire;

  // Rotating priority search. Start at ptr_q and walk upward. The 2-bit index
  // wraps naturally from 3 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ptr_q + k[ADDR_W-1:0];
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Only the owner's bits count. A done strobe and a request drop in the
  // same cycle are one release.
  assign owner_rel = done_i[owner_q] | ~req_i[owner_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  // hold_q counts completed grant cycles. Expiry fires in the last allowed cycle.
  assign expire = (hold_q == 8'(MAX_HOLD - 1));

  // The hold counter clears when a grant is issued and advances while the grant is held.
  always_comb begin
    hold_d = hold_q;
    if (state_q == S_IDLE && win_found) begin
      hold_d = '0;
    end else if (state_q == S_GRANT) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // With no counter, a grant never expires.
  assign expire = 1'b0;
`endif

  // FSM next state and registered output values. Defaults hold every register.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    dec_addr_d = dec_addr_q;
    dec_en_d   = dec_en_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d    = S_GRANT;
          owner_d    = win_idx;
          dec_addr_d = win_idx;
          dec_en_d   = 1'b1;
          grant_d    = NUM_REQ'(1) << win_idx;
          ptr_d      = win_idx + ADDR_W'(1);
        end
      end
      S_GRANT: begin
        if (owner_rel || expire) begin
          state_d    = S_REL;
          dec_addr_d = '0;
          dec_en_d   = 1'b0;
          grant_d    = '0;
          // When the owner releases in the same cycle, a forced release is not reported.
          timeout_d  = expire & ~owner_rel;
        end
      end
      S_REL: begin
        // Turnaround cycle. Requests wait for IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        dec_addr_d = '0;
        dec_en_d   = 1'b0;
        grant_d    = '0;
      end
    endcase
  end

  // State and output registers. Reset wins over everything, including a live grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      dec_addr_q <= '0;
      dec_en_q   <= 1'b0;
      grant_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      dec_addr_q <= dec_addr_d;
      dec_en_q   <= dec_en_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dec_addr_o  = dec_addr_q;
  assign dec_en_o    = dec_en_q;
  assign grant_o     = grant_q;
  assign owner_idx_o = owner_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [1:0] dec_addr;
  logic       dec_en;
  logic [3:0] grant;
  logic [1:0] owner_idx;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  decoder_rr_arbiter #(.NUM_REQ(4), .ADDR_W(2), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .done_i      (done),
    .dec_addr_o  (dec_addr),
    .dec_en_o    (dec_en),
    .grant_o     (grant),
    .owner_idx_o (owner_idx),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model. phase: 0 waiting, 1 owner holds, 2 turnaround.
  int m_ph = 0, m_own = 0, m_ptr = 0, m_hold = 0;
  bit m_to = 0;

  always @(posedge clk) begin
    bit rel, exp_now;
    int w;
    if (rst) begin
      m_ph = 0; m_own = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else begin
      case (m_ph)
        0: begin
          m_to = 0;
          if (req != 4'b0000) begin
            w = -1;
            for (int k = 0; k < 4; k++)
              if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            m_own = w; m_ptr = (w + 1) % 4; m_ph = 1; m_hold = 0;
          end
        end
        1: begin
          rel = done[m_own] || !req[m_own];
`ifdef ARB_TIMEOUT_EN
          exp_now = (m_hold + 1 >= MAX_HOLD);
`else
          exp_now = 0;
`endif
          if (rel || exp_now) begin
            m_ph = 2; m_to = exp_now && !rel;
          end else begin
            m_hold++;
          end
        end
        default: begin
          m_ph = 0; m_to = 0;
        end
      endcase
    end
    #1;
    chk("grant",     grant,     (m_ph == 1) ? (1 << m_own) : 0);
    chk("dec_en",    dec_en,    (m_ph == 1) ? 1 : 0);
    chk("dec_addr",  dec_addr,  (m_ph == 1) ? m_own : 0);
    chk("owner_idx", owner_idx, m_own);
    chk("timeout",   timeout,   m_to);
    chk("onehot0",   $onehot0(grant), 1);
  end

  // Apply inputs, then advance to the next falling edge so that one rising edge has sampled them.
  task automatic step(input logic [3:0] r, input logic [3:0] d);
    req = r; done = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(4'hF, 4'h0);
    step(4'hF, 4'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_order [5];
    logic [3:0] r, d;
    rst = 1'b1; req = 4'h0; done = 4'h0;
    @(negedge clk);

    // T1: reset with every requester asking.
    do_reset();
    chk("T1 grant", grant, 0);
    chk("T1 dec_en", dec_en, 0);
    chk("T1 dec_addr", dec_addr, 0);
    chk("T1 timeout", timeout, 0);

    // T2: a single requester, then a done strobe.
    step(4'b0100, 4'b0000);
    chk("T2 grant", grant, 4'b0100);
    chk("T2 dec_addr", dec_addr, 2);
    chk("T2 dec_en", dec_en, 1);
    step(4'b0100, 4'b0100);
    chk("T2 rel grant", grant, 0);
    step(4'b0000, 4'b0000);
    chk("T2 idle en", dec_en, 0);

    // T3: rotation with every requester asking. The winner order wraps.
    do_reset();
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    step(4'hF, 4'h0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("T3 order%0d", i), grant, exp_order[i]);
      step(4'hF, grant);
      chk($sformatf("T3 rel%0d", i), grant, 0);
      step(4'hF, 4'h0);
      chk($sformatf("T3 turn%0d", i), grant, 0);
      step(4'hF, 4'h0);
    end

    // T4: noise on bits that belong to requesters other than the owner.
    do_reset();
    step(4'b0010, 4'b0000);
    step(4'b0011, 4'b1101);
    chk("T4 noise0", grant, 4'b0010);
    step(4'b0010, 4'b1101);
    chk("T4 noise1", grant, 4'b0010);
    step(4'b0011, 4'b0000);
    chk("T4 noise2", grant, 4'b0010);
    step(4'b0000, 4'b0000);
    chk("T4 release", grant, 0);
    step(4'b0000, 4'b0000);

    // T5: the owner never lets go.
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b1000, 4'b0000);
      chk("T5 held", grant, 4'b1000);
    end
    step(4'b1000, 4'b0000);
    chk("T5 forced grant", grant, 0);
    chk("T5 timeout", timeout, 1);
    step(4'b0000, 4'b0000);
    chk("T5 timeout pulse", timeout, 0);
`else
    for (int i = 0; i < 55; i++) begin
      step(4'b1000, 4'b0000);
      chk("T5 held", grant, 4'b1000);
      chk("T5 no timeout", timeout, 0);
    end
    step(4'b0000, 4'b0000);
`endif
    step(4'b0000, 4'b0000);

    // T6: reset during a grant. The pointer returns to requester 0.
    do_reset();
    step(4'b0100, 4'b0000);
    chk("T6 pre", grant, 4'b0100);
    rst = 1'b1;
    step(4'b0100, 4'b0000);
    chk("T6 drop", grant, 0);
    rst = 1'b0;
    step(4'b0110, 4'b0000);
    chk("T6 ptr0", grant, 4'b0010);

    // Random traffic. Requests are sticky levels with occasional flips; done and reset fire sparsely.
    r = 4'b0110;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 199) == 0);
      step(r, d);
    end
    rst = 1'b0;
    step(4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
